// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet CRC-32 constants and helpers for the RX/TX paths and simulation models.
package eth_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  // Reflected LSB-first update: data[0] is the first bit on the wire.
  function automatic logic [31:0] crc32_step8(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] c;
    c = r;
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC32_POLY_REFL : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/eth_crc32_step8.sv
// eth_crc32_step8: combinational one-octet unroll of the reflected CRC-32 next-state function.
module eth_crc32_step8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  assign o_crc = crc32_step8(i_crc, i_data);
endmodule

// File: rtl/eth_crc32.sv
// eth_crc32: byte-serial IEEE 802.3 CRC-32 generator/checker with wire-ordered FCS output.
// Optional good-frame residue flag crc_ok when ETH_CRC32_CHECK_EN is defined.
module eth_crc32
  import eth_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC32_INIT,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        vld,
  input  logic [7:0]  data,
  output logic [31:0] crc
`ifdef ETH_CRC32_CHECK_EN
  ,
  output logic        crc_ok
`endif
);
  logic [31:0] r_crc;
  logic [31:0] w_next;
  eth_crc32_step8 u_step (
    .i_crc (r_crc),
    .i_data(data),
    .o_crc (w_next)
  );
  always_ff @(posedge clk)
    if (!rstn) r_crc <= CRC_INIT;
    else if (vld) r_crc <= w_next;
  // Output depends on the register only, so crc[31:24] is the first FCS octet sent.
  assign crc = bswap32(r_crc ^ CRC_XOROUT);
`ifdef ETH_CRC32_CHECK_EN
  assign crc_ok = (r_crc == CRC32_RESIDUE);
`endif
endmodule

// File: tb/tb_eth_crc32.sv
// tb_eth_crc32: scoreboard bench for eth_crc32; checks crc_ok too when ETH_CRC32_CHECK_EN is defined.
module tb_eth_crc32;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [31:0] crc;
`ifdef ETH_CRC32_CHECK_EN
  logic        crc_ok;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] m;
  logic [31:0] q[$];
  logic [7:0]  frm[60];
  logic [31:0] f;
  eth_crc32 dut (
    .clk (clk),
    .rstn(rstn),
    .vld (vld),
    .data(data),
    .crc (crc)
`ifdef ETH_CRC32_CHECK_EN
    ,
    .crc_ok(crc_ok)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mstep(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] x;
    logic fb;
    x = r;
    for (int i = 0; i < 8; i++) begin
      fb = x[0] ^ d[i];
      x = x >> 1;
      if (fb) x = x ^ 32'hEDB88320;
    end
    return x;
  endfunction
  function automatic logic [31:0] mout(input logic [31:0] r);
    logic [31:0] x;
    x = ~r;
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic rn);
    vld = v;
    data = d;
    rstn = rn;
    if (!rn) m = 32'hFFFFFFFF;
    else if (v) m = mstep(m, d);
    q.push_back(mout(m));
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else chk("crc", crc, q.pop_front());
  endtask
  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0);
  endtask
  task automatic check_str(input int gaps);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 8'h31 + 8'(i), 1'b1);
      if (gaps != 0) repeat ($urandom_range(1, 5)) cyc(1'b0, 8'($urandom), 1'b1);
    end
    chk("check_value", crc, 32'h2639F4CB);
  endtask
  task automatic frame_fcs(input int flip);
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 60; i++) cyc(1'b1, frm[i], 1'b1);
    f = mout(m);
    for (int k = 0; k < 4; k++) begin
      b = 8'(f >> (24 - 8 * k));
      if (flip == k) b = b ^ 8'h10;
      cyc(1'b1, b, 1'b1);
    end
  endtask
  initial begin
    for (int i = 0; i < 60; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
    frm[7] = 8'h0A;
    frm[8] = 8'h35;
    frm[9] = 8'h01;
    frm[10] = 8'h02;
    frm[11] = 8'h03;
    frm[12] = 8'h08;
    @(negedge clk);
    do_reset();
    do_reset();
    cyc(1'b0, 8'h5A, 1'b1);
    cyc(1'b0, 8'hC3, 1'b1);
    chk("reset_crc", crc, 32'h00000000);
`ifdef ETH_CRC32_CHECK_EN
    chk("reset_ok", 32'(crc_ok), 32'd0);
`endif
    check_str(0);
    do_reset();
    check_str(1);
    frame_fcs(-1);
    chk("residue_crc", crc, 32'h1CDF4421);
`ifdef ETH_CRC32_CHECK_EN
    chk("good_ok", 32'(crc_ok), 32'd1);
`endif
    frame_fcs(2);
`ifdef ETH_CRC32_CHECK_EN
    chk("bad_ok", 32'(crc_ok), 32'd0);
`endif
    do_reset();
    cyc(1'b1, 8'h31, 1'b1);
    cyc(1'b1, 8'h32, 1'b1);
    cyc(1'b1, 8'hAA, 1'b0);
    check_str(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_crc32.md
Name: eth_crc32

Overview:
- Byte-serial Ethernet (IEEE 802.3) CRC-32 generator/checker.
- Accumulates one octet per clock when `vld` is high.
- Presents the running FCS on `crc`, byte-ordered so that `crc[31:24]` is the first FCS octet on the wire.
- Used by the RMII RX path (frame checking) and the TX path (FCS append); also used by simulation models to build frames.

Parameters:
- CRC_INIT, 32'hFFFF_FFFF: value loaded into the internal register on reset (reflected domain).
- CRC_XOROUT, 32'hFFFF_FFFF: value XORed onto the register before the output byte swap.

Ports:
- clk, input, 1: single clock (RMII 50 MHz in the MAC); all state updates on the rising edge.
- rstn, input, 1: synchronous active-low reset; starts a new frame.
- vld, input, 1: `data` carries a valid octet this cycle.
- data, input, 8: frame octet; bit 0 is the first bit on the wire.
- crc, output, 32: current FCS, registered-state derived, byte-swapped (see Behaviour).

Behaviour:
- Internal 32-bit register R, reflected LSB-first CRC-32.
  - Polynomial 0x04C11DB7; reflected constant 0xEDB88320.
- Reset: on a rising edge with rstn=0, R <= CRC_INIT. Reset has priority over `vld`; an octet presented during reset is discarded.
- Update: on a rising edge with rstn=1 and vld=1, R <= step8(R, data).
  - step8 applies 8 single-bit steps, data[0] first.
  - Each step: fb = R[0]^d; R = (R>>1) ^ (fb ? 0xEDB88320 : 0).
- Hold: with vld=0, R is unchanged. Gaps between octets are allowed without limit.
- Output: F = R ^ CRC_XOROUT; crc = {F[7:0], F[15:8], F[23:16], F[31:24]}.
  - crc is combinational from R only; no path from `data` or `vld` to `crc`.
- Latency: an octet accepted at edge N is reflected in `crc` after edge N (visible for the whole cycle N..N+1). Back-to-back octets are accepted every cycle.
- Reset output value: R=0xFFFFFFFF gives crc=32'h0000_0000.
- Transmit usage: after the last payload/pad octet, the wire FCS is crc[31:24], crc[23:16], crc[15:8], crc[7:0] in that order, each octet LSB first.
- Mid-frame reset: aborts the frame immediately; the next accepted octet starts a fresh CRC.
- No X propagation: `data` is ignored when vld=0.

Optional Feature:
- Macro: ETH_CRC32_CHECK_EN.
- When defined:
  - Adds output port `crc_ok` (1 bit). It is combinational from R and high when R == 32'hDEBB20E3, i.e. the good-frame residue after the frame plus its received FCS has been fed through.
  - Reset value of `crc_ok` is 0, since R = CRC_INIT differs from the residue.
- When undefined: port and comparator are absent; all other behaviour is identical.

Decomposition:
- Package eth_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320;
  - CRC32_INIT = 32'hFFFFFFFF;
  - CRC32_RESIDUE = 32'hDEBB20E3;
  - function bswap32;
  - function crc32_step8(R, data), shared with the TX path and the bench.
- One natural sub-module: eth_crc32_step8, a purely combinational 8-bit next-state unroll (R, data -> R_next). eth_crc32 wraps it with the register, reset, output XOR/swap and optional checker.

Test Plan:
- Reset only: rstn=0 for 2 cycles, then idle -> crc=32'h00000000; with CHECK_EN, crc_ok=0.
- ASCII "123456789" (0x31..0x39) back-to-back, vld=1 -> crc=32'h2639F4CB, the byte-swap of the standard check value 0xCBF43926.
- Same 9 octets with random vld=0 gaps (1-5 cycles) between octets -> crc=32'h2639F4CB; crc is stable during gaps.
- 60-octet frame (dst FF×6, src 00 0A 35 01 02 03, type 0800, zero pad) followed by its 4 FCS octets in crc[31:24]-first order -> with CHECK_EN, crc_ok=1 after the last FCS octet, and R=0xDEBB20E3.
- Flip one bit in any FCS octet of the previous case -> crc_ok=0.
- Mid-frame reset: feed 0x31 0x32, assert rstn=0 for one cycle while vld=1 with data 0xAA, then feed "123456789" -> crc=32'h2639F4CB (the 0xAA octet is ignored).
